// File: rtl/i2c_slave_txn_ctrl.sv
// Transaction sequencer for the EPT I2C slave: steers the byte shifter and ack unit,
// decodes the device address, drives register-file strobes and aborts stalled transfers.
module i2c_slave_txn_ctrl #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START_DET,
    input  logic       STOP_DET,
    input  logic       BYTE_DONE,
    input  logic [7:0] RX_BYTE,
    input  logic       ACK_DONE,
    input  logic       ACK_BIT,
    input  logic [7:0] RD_DATA,
    output logic       RX_START,
    output logic       TX_START,
    output logic [7:0] TX_DATA,
    output logic       ACK_REQ_START,
    output logic       ACK_GNT_START,
    output logic       WR_EN,
    output logic       RD_EN,
    output logic [7:0] REG_ADDR,
    output logic [7:0] WR_DATA,
    output logic       BUSY,
    output logic       TIMEOUT
);

    typedef enum logic [10:0] {
        IDLE     = 11'b000_0000_0001,
        ADDR_RX  = 11'b000_0000_0010,
        ADDR_CHK = 11'b000_0000_0100,
        ACK_TX   = 11'b000_0000_1000,
        DATA_RX  = 11'b000_0001_0000,
        WRITE    = 11'b000_0010_0000,
        RD_REQ   = 11'b000_0100_0000,
        RD_LOAD  = 11'b000_1000_0000,
        DATA_TX  = 11'b001_0000_0000,
        ACK_RX   = 11'b010_0000_0000,
        ACK_CHK  = 11'b100_0000_0000
    } state_t;

    state_t      state, next_state;
    logic        entry_q;
    logic [15:0] wdog;
    logic        in_wait, restart, timeout_hit, change, local_ev;
    logic [7:0]  addr_byte;
    logic        rw_q, first_byte, ack_bit_q;
    logic [7:0]  reg_addr_q, tx_data_q, wr_data_q;

    assign in_wait = (state == ADDR_RX) || (state == ACK_TX) || (state == DATA_RX) ||
                     (state == DATA_TX) || (state == ACK_RX);
    // A START seen while already in ADDR_RX still counts as a fresh entry.
    assign change   = (next_state != state) || restart;
    assign local_ev = !STOP_DET && !START_DET && !timeout_hit;

    always_comb begin
        next_state  = state;
        restart     = 1'b0;
        timeout_hit = 1'b0;
        if (STOP_DET) begin
            next_state = IDLE;
        end else if (START_DET) begin
            next_state = ADDR_RX;
            restart    = 1'b1;
        end else if (in_wait && (wdog == TIMEOUT_CYC - 16'd1)) begin
            next_state  = IDLE;
            timeout_hit = 1'b1;
        end else begin
            case (state)
                ADDR_RX:  if (BYTE_DONE) next_state = ADDR_CHK;
                ADDR_CHK: next_state = (addr_byte[7:1] == SLAVE_ADDR) ? ACK_TX : IDLE;
                ACK_TX:   if (ACK_DONE) next_state = rw_q ? RD_REQ : DATA_RX;
                DATA_RX:  if (BYTE_DONE) next_state = first_byte ? ACK_TX : WRITE;
                WRITE:    next_state = ACK_TX;
                RD_REQ:   next_state = RD_LOAD;
                RD_LOAD:  next_state = DATA_TX;
                DATA_TX:  if (BYTE_DONE) next_state = ACK_RX;
                ACK_RX:   if (ACK_DONE) next_state = ACK_CHK;
                ACK_CHK:  next_state = ack_bit_q ? IDLE : RD_REQ;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            entry_q <= 1'b0;
            wdog    <= '0;
        end else begin
            state   <= next_state;
            entry_q <= change;
            wdog    <= (change || !in_wait) ? 16'd0 : wdog + 16'd1;
        end
    end

    // Datapath registers advance only when no global event or abort overrides the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_byte  <= '0;
            rw_q       <= 1'b0;
            first_byte <= 1'b1;
            ack_bit_q  <= 1'b0;
            reg_addr_q <= '0;
            tx_data_q  <= '0;
            wr_data_q  <= '0;
        end else if (local_ev) begin
            case (state)
                ADDR_RX: if (BYTE_DONE) begin
                    addr_byte  <= RX_BYTE;
                    first_byte <= 1'b1;
                end
                ADDR_CHK: rw_q <= addr_byte[0];
                DATA_RX: if (BYTE_DONE) begin
                    if (first_byte) begin
                        reg_addr_q <= RX_BYTE;
                        first_byte <= 1'b0;
                    end else begin
                        wr_data_q <= RX_BYTE;
                    end
                end
                WRITE:   reg_addr_q <= reg_addr_q + 8'd1;
                RD_LOAD: tx_data_q  <= RD_DATA;
                ACK_RX:  if (ACK_DONE) ack_bit_q <= ACK_BIT;
                ACK_CHK: reg_addr_q <= reg_addr_q + 8'd1;
                default: ;
            endcase
        end
    end

    // Entry pulses fire only in the first cycle spent in a state.
    assign RX_START      = entry_q && ((state == ADDR_RX) || (state == DATA_RX));
    assign ACK_GNT_START = entry_q && (state == ACK_TX);
    assign TX_START      = entry_q && (state == DATA_TX);
    assign ACK_REQ_START = entry_q && (state == ACK_RX);
    assign WR_EN         = (state == WRITE);
    assign RD_EN         = (state == RD_REQ);
    assign BUSY          = (state != IDLE);
    assign TIMEOUT       = timeout_hit;
    assign REG_ADDR      = reg_addr_q;
    assign TX_DATA       = tx_data_q;
    assign WR_DATA       = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_txn_ctrl.sv
// Self-checking bench for i2c_slave_txn_ctrl: a reactive bus master plus a transaction-level
// model (pointer, register file, expected strobes) checked by one per-cycle compare process.
module tb_i2c_slave_txn_ctrl;

    localparam logic [6:0]  SLV    = 7'h50;
    localparam logic [15:0] TO_CYC = 16'd100;
    localparam int S_RX = 0, S_TX = 1, S_GNT = 2, S_REQ = 3;
    localparam int I_START = 0, I_STOP = 1, I_BYTE = 2, I_ACK = 3;

    logic       CLK = 1'b0, RST_N = 1'b1;
    logic       START_DET = 1'b0, STOP_DET = 1'b0, BYTE_DONE = 1'b0, ACK_DONE = 1'b0, ACK_BIT = 1'b0;
    logic [7:0] RX_BYTE = 8'h00, RD_DATA = 8'h00;
    logic       RX_START, TX_START, ACK_REQ_START, ACK_GNT_START, WR_EN, RD_EN, BUSY, TIMEOUT;
    logic [7:0] TX_DATA, REG_ADDR, WR_DATA;

    int n_chk = 0, n_fail = 0, gnt_cnt = 0;
    logic [7:0]  mem [256];
    logic [7:0]  wbuf [8];
    logic [15:0] wr_q [$], wr_log [$];
    logic [7:0]  rd_q [$], rd_log [$], tx_q [$], tx_log [$];
    logic [7:0]  reg_model = 8'h00;
    bit          quiet = 1'b0, to_ok = 1'b0, rd_en_d = 1'b0;
    logic [6:0]  prev_p = '0;

    i2c_slave_txn_ctrl #(.SLAVE_ADDR(SLV), .TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(CLK), .RST_N(RST_N), .START_DET(START_DET), .STOP_DET(STOP_DET),
        .BYTE_DONE(BYTE_DONE), .RX_BYTE(RX_BYTE), .ACK_DONE(ACK_DONE), .ACK_BIT(ACK_BIT),
        .RD_DATA(RD_DATA), .RX_START(RX_START), .TX_START(TX_START), .TX_DATA(TX_DATA),
        .ACK_REQ_START(ACK_REQ_START), .ACK_GNT_START(ACK_GNT_START), .WR_EN(WR_EN),
        .RD_EN(RD_EN), .REG_ADDR(REG_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare: strobes against the model queues, pulse widths, forbidden activity.
    always @(negedge CLK) begin
        logic [6:0] p;
        p = {TIMEOUT, RD_EN, WR_EN, ACK_REQ_START, ACK_GNT_START, TX_START, RX_START};
        for (int i = 0; i < 7; i++)
            if (p[i] === 1'b1) chk("pulse_one_cycle", 32'(prev_p[i]), 0);
        prev_p = p;
        if (WR_EN === 1'b1) begin
            wr_log.push_back({REG_ADDR, WR_DATA});
            chk("wr_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) chk("wr_addr_data", {REG_ADDR, WR_DATA}, wr_q.pop_front());
        end
        if (RD_EN === 1'b1) begin
            rd_log.push_back(REG_ADDR);
            chk("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) chk("rd_addr", REG_ADDR, rd_q.pop_front());
        end
        if (TX_START === 1'b1) begin
            tx_log.push_back(TX_DATA);
            chk("tx_expected", 32'(tx_q.size() != 0), 1);
            if (tx_q.size() != 0) chk("tx_data", TX_DATA, tx_q.pop_front());
        end
        if (quiet) chk("quiet_bus", 32'(p[5:0]), 0);
        if (TIMEOUT === 1'b1) chk("timeout_allowed", 32'(to_ok), 1);
        if (ACK_GNT_START === 1'b1) gnt_cnt++;
        // Register file: read data appears the cycle after RD_EN, garbage otherwise.
        if (RD_EN === 1'b1) RD_DATA = mem[REG_ADDR];
        else if (!rd_en_d) RD_DATA = 8'($urandom);
        rd_en_d = (RD_EN === 1'b1);
    end

    function automatic logic sig(input int k);
        case (k)
            S_RX:    sig = RX_START;
            S_TX:    sig = TX_START;
            S_GNT:   sig = ACK_GNT_START;
            S_REQ:   sig = ACK_REQ_START;
            default: sig = TIMEOUT;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_in(input int which, input logic [7:0] b, input logic a);
        case (which)
            I_START: START_DET = 1'b1;
            I_STOP:  STOP_DET  = 1'b1;
            I_BYTE:  begin BYTE_DONE = 1'b1; RX_BYTE = b; end
            default: begin ACK_DONE = 1'b1; ACK_BIT = a; end
        endcase
        @(negedge CLK);
        START_DET = 1'b0; STOP_DET = 1'b0; BYTE_DONE = 1'b0; ACK_DONE = 1'b0;
        RX_BYTE = 8'($urandom); ACK_BIT = 1'($urandom);
    endtask

    task automatic respond(input int which, input logic [7:0] b, input logic a);
        tick($urandom_range(1, 6));
        pulse_in(which, b, a);
    endtask

    task automatic expect_out(input int k, input string nm);
        int n;
        n = 0;
        while (sig(k) !== 1'b1 && n < 12) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(sig(k) === 1'b1), 1);
    endtask

    // Write: optional pointer byte then data bytes; ends waiting in the next receive.
    task automatic do_write(input int n, input bit stop);
        tick($urandom_range(1, 3));
        pulse_in(I_START, 0, 0);
        expect_out(S_RX, "w_addr_rx_start");
        respond(I_BYTE, {SLV, 1'b0}, 0);
        expect_out(S_GNT, "w_addr_ack");
        respond(I_ACK, 0, 0);
        for (int i = 0; i < n; i++) begin
            expect_out(S_RX, "w_data_rx_start");
            if (i == 0) reg_model = wbuf[0];
            else begin
                wr_q.push_back({reg_model, wbuf[i]});
                mem[reg_model] = wbuf[i];
                reg_model++;
            end
            respond(I_BYTE, wbuf[i], 0);
            expect_out(S_GNT, "w_data_ack");
            respond(I_ACK, 0, 0);
        end
        expect_out(S_RX, "w_tail_rx_start");
        chk("w_reg_addr", REG_ADDR, reg_model);
        if (stop) begin
            tick($urandom_range(1, 3));
            pulse_in(I_STOP, 0, 0);
            tick(1);
            chk("w_busy_after_stop", BUSY, 0);
        end
    endtask

    // Read n bytes from the current pointer; master ACKs all but the last.
    task automatic do_read(input int n);
        logic [7:0] p;
        p = reg_model;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(p);
            tx_q.push_back(mem[p]);
            p++;
        end
        tick($urandom_range(1, 3));
        pulse_in(I_START, 0, 0);
        expect_out(S_RX, "r_addr_rx_start");
        respond(I_BYTE, {SLV, 1'b1}, 0);
        expect_out(S_GNT, "r_addr_ack");
        respond(I_ACK, 0, 0);
        for (int i = 0; i < n; i++) begin
            expect_out(S_TX, "r_tx_start");
            respond(I_BYTE, 8'($urandom), 0);
            expect_out(S_REQ, "r_ack_req");
            respond(I_ACK, 0, (i == n - 1));
            reg_model++;
        end
        tick(3);
        chk("r_busy_after_nack", BUSY, 0);
        chk("r_reg_addr", REG_ADDR, reg_model);
    endtask

    task automatic do_mismatch();
        logic [7:0] a;
        a = 8'($urandom);
        while (a[7:1] == SLV) a = 8'($urandom);
        tick($urandom_range(1, 3));
        pulse_in(I_START, 0, 0);
        expect_out(S_RX, "m_addr_rx_start");
        respond(I_BYTE, a, 0);
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            respond(I_BYTE, 8'($urandom), 0);
            respond(I_ACK, 0, 0);
        end
        chk("m_busy", BUSY, 0);
        chk("m_reg_addr", REG_ADDR, reg_model);
        quiet = 1'b0;
    endtask

    task automatic drained(input string nm);
        chk({nm, "_wr_q_empty"}, wr_q.size(), 0);
        chk({nm, "_rd_q_empty"}, rd_q.size(), 0);
        chk({nm, "_tx_q_empty"}, tx_q.size(), 0);
    endtask

    task automatic run_random(input int count);
        int kind, n;
        for (int t = 0; t < count; t++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                n = $urandom_range(0, 5);
                for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
                do_write(n, 1'($urandom));
            end else if (kind == 2) begin
                do_read($urandom_range(1, 4));
            end else begin
                do_mismatch();
            end
            drained("rand");
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        #1 RST_N = 1'b0;
        tick(3);
        chk("reset_pulses", {RX_START, TX_START, ACK_REQ_START, ACK_GNT_START, WR_EN, RD_EN, TIMEOUT}, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_reg_addr", REG_ADDR, 8'h00);
        chk("reset_tx_wr_data", {TX_DATA, WR_DATA}, 16'h0000);
        RST_N = 1'b1;
        tick(2);

        // Directed write: pointer 0x10, data 0x5A, 0x6B.
        gnt_cnt = 0; wr_log.delete();
        wbuf[0] = 8'h10; wbuf[1] = 8'h5A; wbuf[2] = 8'h6B;
        do_write(3, 1'b1);
        chk("dw_ack_gnt_count", gnt_cnt, 4);
        chk("dw_write_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("dw_write0", wr_log[0], 16'h105A);
            chk("dw_write1", wr_log[1], 16'h116B);
        end
        chk("dw_final_reg_addr", REG_ADDR, 8'h12);
        drained("dw");

        // Directed read with repeated START and pointer wrap.
        rd_log.delete(); tx_log.delete();
        mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;
        wbuf[0] = 8'hFE;
        do_write(1, 1'b0);
        do_read(2);
        chk("dr_read_count", tx_log.size(), 2);
        if (tx_log.size() == 2 && rd_log.size() == 2) begin
            chk("dr_tx0", tx_log[0], 8'h33);
            chk("dr_tx1", tx_log[1], 8'h44);
            chk("dr_rd_addr0", rd_log[0], 8'hFE);
            chk("dr_rd_addr1", rd_log[1], 8'hFF);
        end
        chk("dr_wrap_reg_addr", REG_ADDR, 8'h00);
        drained("dr");

        // Address mismatch then ignored traffic.
        do_mismatch();

        // STOP and START together mid-write.
        wbuf[0] = 8'h40;
        do_write(1, 1'b0);
        tick(1);
        quiet = 1'b1;
        START_DET = 1'b1; STOP_DET = 1'b1;
        @(negedge CLK);
        START_DET = 1'b0; STOP_DET = 1'b0;
        tick(3);
        chk("ss_busy", BUSY, 0);
        chk("ss_reg_addr", REG_ADDR, 8'h40);
        quiet = 1'b0;

        // Stall after address ACK: watchdog abort.
        do_write(0, 1'b0);
        tick(1);
        n = 1;
        quiet = 1'b1; to_ok = 1'b1;
        while (TIMEOUT !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("to_seen", 32'(TIMEOUT === 1'b1), 1);
        chk("to_latency", n, 32'(TO_CYC) - 1);
        tick(1);
        chk("to_busy", BUSY, 0);
        quiet = 1'b0; to_ok = 1'b0;

        // Async reset during DATA_TX.
        wbuf[0] = 8'h20; mem[8'h20] = 8'h9C;
        do_write(1, 1'b0);
        rd_q.push_back(8'h20); tx_q.push_back(8'h9C);
        tick(1);
        pulse_in(I_START, 0, 0);
        expect_out(S_RX, "ar_addr_rx_start");
        respond(I_BYTE, {SLV, 1'b1}, 0);
        expect_out(S_GNT, "ar_addr_ack");
        respond(I_ACK, 0, 0);
        expect_out(S_TX, "ar_tx_start");
        #3 RST_N = 1'b0;
        #1;
        chk("ar_pulses", {RX_START, TX_START, ACK_REQ_START, ACK_GNT_START, WR_EN, RD_EN, TIMEOUT}, 0);
        chk("ar_busy", BUSY, 0);
        chk("ar_reg_addr", REG_ADDR, 8'h00);
        chk("ar_tx_data", TX_DATA, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        reg_model = 8'h00;
        wr_q.delete(); rd_q.delete(); tx_q.delete();
        for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
        do_write(3, 1'b1);
        do_read(2);
        drained("ar");

        run_random(30);
        tick(1);
        pulse_in(I_STOP, 0, 0);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: time %0t, required completion before 500000", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
